// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the five pipeline registers.
// Merges per-stage stall requests into one stall vector, runs the
// exception flush / PC redirect sequence, drains an in-flight instruction
// fetch before redirecting, and flags stall runs that last too long.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_RUN   | normal operation; stall vector follows the stage requests
//  ST_FLUSH | one cycle: flush every pipeline register, redirect if fetch idle
//  ST_DRAIN | hold PC/IF until the outstanding fetch returns, then redirect
module pipeline_ctrl #(
  parameter int unsigned STALL_LIMIT = 1024,
  parameter int unsigned CNT_WIDTH   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_if_i,
  input  logic        stall_req_id_i,
  input  logic        stall_req_ex_i,
  input  logic        stall_req_mem_i,
  input  logic        exc_req_i,
  input  logic [31:0] exc_target_pc_i,
  input  logic        if_busy_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        discard_fetch_o,
  output logic        stall_timeout_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STALL_LIMIT);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_redirect_pc;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic                 r_timeout;

  logic [5:0]           w_req_stall;
  logic                 w_any_req;
  logic                 w_load_pc;
  logic                 w_cnt_inc;
  logic [CNT_WIDTH-1:0] w_cnt_plus1;

  // Request merge: freeze every stage up to the deepest requester, so a
  // bubble is inserted directly behind it. WB is never stalled by a request.
  always_comb begin
    w_req_stall = 6'b000000;
    if (stall_req_mem_i)     w_req_stall = 6'b011111;
    else if (stall_req_ex_i) w_req_stall = 6'b001111;
    else if (stall_req_id_i) w_req_stall = 6'b000111;
    else if (stall_req_if_i) w_req_stall = 6'b000011;
  end

  assign w_any_req = stall_req_if_i | stall_req_id_i | stall_req_ex_i | stall_req_mem_i;

  // Next-state and output decode; exceptions and requests only matter in RUN
  // because FLUSH/DRAIN operate on an already emptied pipe.
  always_comb begin
    w_state_nxt      = r_state;
    stall_o          = 6'b000000;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    discard_fetch_o  = 1'b0;
    w_load_pc        = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (exc_req_i) begin
          stall_o     = 6'b111111;
          w_load_pc   = 1'b1;
          w_state_nxt = ST_FLUSH;
        end else begin
          stall_o = w_req_stall;
        end
      end
      ST_FLUSH: begin
        flush_o = 1'b1;
        if (if_busy_i) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          redirect_valid_o = 1'b1;
          w_state_nxt      = ST_RUN;
        end
      end
      ST_DRAIN: begin
        stall_o = 6'b000011;
        if (if_busy_i) begin
          discard_fetch_o = 1'b1;
        end else begin
          redirect_valid_o = 1'b1;
          w_state_nxt      = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Capture the exception target when the exception is accepted in RUN.
  always_ff @(posedge clk) begin
    if (rst)            r_redirect_pc <= 32'h0000_0000;
    else if (w_load_pc) r_redirect_pc <= exc_target_pc_i;
  end

  assign w_cnt_inc   = (r_state == ST_RUN) && !exc_req_i && w_any_req;
  assign w_cnt_plus1 = r_stall_cnt + CNT_WIDTH'(1);

  // Stall-run monitor: counts consecutive request-stalled RUN cycles and
  // latches a sticky flag once the run reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else if (w_cnt_inc) begin
      if (r_stall_cnt != LIMIT) r_stall_cnt <= w_cnt_plus1;
      if (w_cnt_plus1 == LIMIT) r_timeout   <= 1'b1;
    end else begin
      r_stall_cnt <= '0;
    end
  end

  assign redirect_pc_o   = r_redirect_pc;
  assign stall_timeout_o = r_timeout;

endmodule
